// File: rtl/approx_mult_err_sweeper.sv
// -----------------------------------------------------------------------------
// approx_mult_err_sweeper
//
// Stimulus/checker end of an approximate multiplier's a/b -> y interface.
// Issues every (a,b) pair once (a outer loop, b inner loop), samples the
// multiplier's product LAT clocks later, and accumulates:
//   err_count : number of pairs whose product differs from a*b
//   sum_ed    : sum of absolute error distances |y - a*b|
//   max_ed    : largest absolute error distance seen
//
// Optional feature (define MULT_SWEEP_WORST_EN):
//   adds worst_a/worst_b, the operands of the first pair that set the current
//   max_ed. Without the macro those ports and registers do not exist.
// -----------------------------------------------------------------------------
module approx_mult_err_sweeper #(
    parameter int WIDTH = 8,
    parameter int LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [2*WIDTH-1:0]   y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH:0]     sum_ed,
    output logic [2*WIDTH-1:0]   max_ed
`ifdef MULT_SWEEP_WORST_EN
    ,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_b
`endif
);

    localparam int PW = 2 * WIDTH;       // product width
    localparam int EW = 2 * WIDTH + 1;   // error counter width
    localparam int SW = 4 * WIDTH + 1;   // ED sum width
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [WIDTH-1:0] OP_MAX     = {WIDTH{1'b1}};
    localparam logic [DW-1:0]    DRAIN_LAST = DW'((LAT > 0) ? (LAT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One compare-pipe entry: the exact product travels with its valid bit
    // (and, with the optional feature, with the operands that produced it).
    typedef struct packed {
        logic             valid;
        logic [PW-1:0]    exact;
`ifdef MULT_SWEEP_WORST_EN
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
`endif
    } cmp_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [EW-1:0]     err_q, err_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [PW-1:0]     max_q, max_d;
`ifdef MULT_SWEEP_WORST_EN
    logic [WIDTH-1:0]  worst_a_q, worst_a_d;
    logic [WIDTH-1:0]  worst_b_q, worst_b_d;
`endif

    logic              start_accept;
    logic              last_pair;
    cmp_t              issue;     // entry for the pair presented this cycle
    cmp_t              cmp;       // entry whose product is sampled this cycle
    logic [PW-1:0]     ed;

    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_pair    = (a_q == OP_MAX) && (b_q == OP_MAX);

    // Build the pipe entry for the pair currently on a_out/b_out.
    always_comb begin
        issue       = '0;
        issue.valid = (state_q == S_SWEEP);
        issue.exact = PW'(a_q) * PW'(b_q);
`ifdef MULT_SWEEP_WORST_EN
        issue.a     = a_q;
        issue.b     = b_q;
`endif
    end

    // Latency pipe: the product returned LAT clocks later is matched against
    // the entry that has just reached the last stage.
    if (LAT > 0) begin : g_pipe
        cmp_t pipe_q [LAT];
        cmp_t pipe_d [LAT];

        // Shift the issued entry in at stage 0.
        always_comb begin
            pipe_d[0] = issue;
            for (int i = 1; i < LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        // Pipe storage; every stage is cleared so no stale valid bit survives reset.
        // NOTE: this is a small register array, not a RAM, so resetting it is
        // cheap and required: a stale valid bit would corrupt the accumulators.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign cmp = pipe_q[LAT-1];
    end else begin : g_nopipe
        // Combinational multiplier: its product belongs to the live pair.
        assign cmp = issue;
    end

    // Absolute error distance; the magnitude of a difference of two PW-bit
    // unsigned values always fits in PW bits.
    assign ed = (y_in >= cmp.exact) ? (y_in - cmp.exact) : (cmp.exact - y_in);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // FSM next state: IDLE/DONE -> SWEEP -> (DRAIN) -> DONE.
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (last_pair) begin
                    if (LAT > 0) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: busy spans SWEEP and DRAIN, done is the DONE level.
    always_comb begin
        busy = (state_q == S_SWEEP) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // Operand counters: b inner, a outer; both wrap back to 0 after (max,max).
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (start_accept) begin
            a_d = '0;
            b_d = '0;
        end else if (state_q == S_SWEEP) begin
            b_d = b_q + WIDTH'(1);
            if (b_q == OP_MAX) begin
                a_d = a_q + WIDTH'(1);
            end
        end
    end

    // Accumulators: cleared by an accepted start, updated on valid compares.
    always_comb begin
        err_d = err_q;
        sum_d = sum_q;
        max_d = max_q;
`ifdef MULT_SWEEP_WORST_EN
        worst_a_d = worst_a_q;
        worst_b_d = worst_b_q;
`endif
        if (start_accept) begin
            err_d = '0;
            sum_d = '0;
            max_d = '0;
`ifdef MULT_SWEEP_WORST_EN
            worst_a_d = '0;
            worst_b_d = '0;
`endif
        end else if (cmp.valid) begin
            if (ed != '0) begin
                err_d = err_q + EW'(1);
            end
            sum_d = sum_q + SW'(ed);
            // Strict compare keeps the first pair that reached a given max.
            if (ed > max_q) begin
                max_d = ed;
`ifdef MULT_SWEEP_WORST_EN
                worst_a_d = cmp.a;
                worst_b_d = cmp.b;
`endif
            end
        end
    end

    // Datapath registers: operands and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
`ifdef MULT_SWEEP_WORST_EN
            worst_a_q <= '0;
            worst_b_q <= '0;
`endif
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            err_q <= err_d;
            sum_q <= sum_d;
            max_q <= max_d;
`ifdef MULT_SWEEP_WORST_EN
            worst_a_q <= worst_a_d;
            worst_b_q <= worst_b_d;
`endif
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
`ifdef MULT_SWEEP_WORST_EN
    assign worst_a   = worst_a_q;
    assign worst_b   = worst_b_q;
`endif

endmodule
